// File: rtl/riscv_magic_mem_pkg.sv
// Shared types and constants for the riscv magic memory responder.
package riscv_magic_mem_pkg;

    // One posted store held in the store buffer: word address plus data.
    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] data;
    } wb_entry_t;

    // addi x0, x0, 0 -- returned for fetches that fall outside the array.
    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    // True when a 30-bit word address lands inside a 2**depth_log2 word array.
    function automatic logic addr_in_range(input logic [29:0] addr,
                                           input int unsigned depth_log2);
        return (addr >> depth_log2) == 30'd0;
    endfunction

endpackage

// File: rtl/riscv_magic_mem_if.sv
// Bus between the core (or testbench) and the magic memory: fetch port,
// data port, program-load backdoor and store-buffer status.
interface riscv_magic_mem_if #(
    parameter int DEPTH_LOG2 = 10,
    parameter int WB_DEPTH   = 4
);
    localparam int CW = $clog2(WB_DEPTH) + 1;

    logic [29:0]           pc;
    logic [31:0]           instr;
    logic [29:0]           mem_addr;
    logic                  mem_write;
    logic [31:0]           mem_write_data;
    logic [31:0]           mem_read_data;
    logic                  ld_en;
    logic [DEPTH_LOG2-1:0] ld_addr;
    logic [31:0]           ld_data;
    logic [CW-1:0]         wb_count;
    logic                  wb_full;
    logic                  wb_overflow;
    logic                  addr_fault;

    modport master (
        output pc, mem_addr, mem_write, mem_write_data, ld_en, ld_addr, ld_data,
        input  instr, mem_read_data, wb_count, wb_full, wb_overflow, addr_fault
    );

    modport slave (
        input  pc, mem_addr, mem_write, mem_write_data, ld_en, ld_addr, ld_data,
        output instr, mem_read_data, wb_count, wb_full, wb_overflow, addr_fault
    );

endinterface

// File: rtl/riscv_store_buffer.sv
// Count-based store FIFO with two parallel address-match lookups.
// Each lookup reports the youngest valid entry whose address matches.
module riscv_store_buffer
    import riscv_magic_mem_pkg::*;
#(
    parameter  int WB_DEPTH = 4,
    localparam int PW       = $clog2(WB_DEPTH),
    localparam int CW       = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  wb_entry_t     push_entry,
    input  logic          pop,
    output wb_entry_t     head,
    output logic [CW-1:0] count,
    output logic          full,
    input  logic [29:0]   look_a_addr,
    output logic          hit_a,
    output logic [31:0]   data_a,
    input  logic [29:0]   look_b_addr,
    output logic          hit_b,
    output logic [31:0]   data_b
);

    wb_entry_t     entries [WB_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          pop_ok;
    logic          push_ok;

    assign full    = (count == CW'(WB_DEPTH));
    assign pop_ok  = pop && (count != '0);
    assign push_ok = push && (!full || pop_ok);
    assign head    = entries[rd_ptr];

    // Pointers and occupancy; pending entries are discarded by clearing the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset: validity comes entirely from the count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            entries[wr_ptr] <= push_entry;
        end
    end

    // Walk oldest to youngest so a later (younger) match overrides an older one.
    always_comb begin
        logic [PW-1:0] idx;
        idx    = '0;
        hit_a  = 1'b0;
        data_a = '0;
        hit_b  = 1'b0;
        data_b = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (CW'(i) < count) begin
                if (entries[idx].addr == look_a_addr) begin
                    hit_a  = 1'b1;
                    data_a = entries[idx].data;
                end
                if (entries[idx].addr == look_b_addr) begin
                    hit_b  = 1'b1;
                    data_b = entries[idx].data;
                end
            end
        end
    end

endmodule

// File: rtl/riscv_magic_mem.sv
// Magic memory for the single-cycle riscv core: combinational fetch and
// load ports, posted stores through a small store buffer with forwarding,
// and a backdoor program-load port that owns the array write port when used.
module riscv_magic_mem
    import riscv_magic_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int WB_DEPTH   = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    riscv_magic_mem_if.slave     bus
);

    localparam int CW = $clog2(WB_DEPTH) + 1;

    logic [31:0]   mem [2**DEPTH_LOG2];

    wb_entry_t     push_entry;
    wb_entry_t     head;
    logic [CW-1:0] wb_count;
    logic          wb_full;
    logic          data_in_range;
    logic          pc_in_range;
    logic          head_in_range;
    logic          drain;
    logic          push;
    logic          drop_full;
    logic          fwd_data_hit;
    logic [31:0]   fwd_data;
    logic          fwd_pc_hit;
    logic [31:0]   fwd_pc;
    logic          wb_overflow;
    logic          addr_fault;

    assign data_in_range = addr_in_range(bus.mem_addr, DEPTH_LOG2);
    assign pc_in_range   = addr_in_range(bus.pc, DEPTH_LOG2);
    assign head_in_range = addr_in_range(head.addr, DEPTH_LOG2);

    // The backdoor steals the array write port, so draining waits while it is busy.
    assign drain     = !bus.ld_en && (wb_count != '0);
    assign push      = bus.mem_write && data_in_range && (!wb_full || drain);
    assign drop_full = bus.mem_write && data_in_range && wb_full && !drain;

    assign push_entry.addr = bus.mem_addr;
    assign push_entry.data = bus.mem_write_data;

    riscv_store_buffer #(
        .WB_DEPTH (WB_DEPTH)
    ) u_store_buffer (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (drain),
        .head        (head),
        .count       (wb_count),
        .full        (wb_full),
        .look_a_addr (bus.mem_addr),
        .hit_a       (fwd_data_hit),
        .data_a      (fwd_data),
        .look_b_addr (bus.pc),
        .hit_b       (fwd_pc_hit),
        .data_b      (fwd_pc)
    );

    // Single array write port: program load first, otherwise the oldest buffered store.
    always_ff @(posedge clk) begin
        if (bus.ld_en) begin
            mem[bus.ld_addr] <= bus.ld_data;
        end else if (drain && head_in_range) begin
            mem[head.addr[DEPTH_LOG2-1:0]] <= head.data;
        end
    end

    // Load data: out-of-range reads return zero, buffered stores shadow the array.
    always_comb begin
        bus.mem_read_data = '0;
        if (data_in_range) begin
            if (fwd_data_hit) begin
                bus.mem_read_data = fwd_data;
            end else begin
                bus.mem_read_data = mem[bus.mem_addr[DEPTH_LOG2-1:0]];
            end
        end
    end

    // Fetch: same forwarding as loads, but out-of-range pcs see a NOP.
    always_comb begin
        bus.instr = RV_NOP;
        if (pc_in_range) begin
            if (fwd_pc_hit) begin
                bus.instr = fwd_pc;
            end else begin
                bus.instr = mem[bus.pc[DEPTH_LOG2-1:0]];
            end
        end
    end

    // Sticky error flags; the data port has no read strobe, so any cycle
    // presenting an out-of-range data address counts as a faulting access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_overflow <= 1'b0;
            addr_fault  <= 1'b0;
        end else begin
            if (drop_full) begin
                wb_overflow <= 1'b1;
            end
            if (!data_in_range) begin
                addr_fault <= 1'b1;
            end
        end
    end

    assign bus.wb_count    = wb_count;
    assign bus.wb_full     = wb_full;
    assign bus.wb_overflow = wb_overflow;
    assign bus.addr_fault  = addr_fault;

endmodule

// File: tb/tb_riscv_magic_mem.sv
// Directed bench for riscv_magic_mem: forwarding, store-buffer fill and
// overflow, same-address ordering, range faults, reset and fetch forwarding.
module tb_riscv_magic_mem;

    localparam int DEPTH_LOG2 = 10;
    localparam int WB_DEPTH   = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    riscv_magic_mem_if #(.DEPTH_LOG2(DEPTH_LOG2), .WB_DEPTH(WB_DEPTH)) bus ();

    riscv_magic_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WB_DEPTH   (WB_DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [29:0] addr, input logic wr,
                                  input logic [31:0] wdata, input logic ld,
                                  input logic [DEPTH_LOG2-1:0] laddr,
                                  input logic [31:0] ldata);
        bus.mem_addr       = addr;
        bus.mem_write      = wr;
        bus.mem_write_data = wdata;
        bus.ld_en          = ld;
        bus.ld_addr        = laddr;
        bus.ld_data        = ldata;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [DEPTH_LOG2-1:0] pre_addr [5];
        logic [31:0]           pre_data [5];

        checks   = 0;
        failures = 0;
        pre_addr = '{10'd0, 10'd5, 10'd6, 10'd9, 10'd20};
        pre_data = '{32'hCAFE_F00D, 32'h1111_1111, 32'h6666_6666,
                     32'h9999_9999, 32'h2020_2020};

        // Reset state
        rst_n  = 1'b0;
        bus.pc = '0;
        apply_stimulus(30'd0, 1'b0, 32'd0, 1'b0, '0, 32'd0);
        tick();
        tick();
        check_output("rst_count",    32'(bus.wb_count),    32'd0);
        check_output("rst_full",     32'(bus.wb_full),     32'd0);
        check_output("rst_overflow", 32'(bus.wb_overflow), 32'd0);
        check_output("rst_fault",    32'(bus.addr_fault),  32'd0);
        #2 rst_n = 1'b1;
        tick();

        // Program the array through the backdoor
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(30'd0, 1'b0, 32'd0, 1'b1, pre_addr[i], pre_data[i]);
            tick();
        end
        apply_stimulus(30'd5, 1'b0, 32'd0, 1'b0, '0, 32'd0);
        #1 check_output("preload_5", bus.mem_read_data, 32'h1111_1111);

        // Store then load the same address: forwarded next cycle, array one cycle later
        apply_stimulus(30'd5, 1'b1, 32'hDEAD_BEEF, 1'b0, '0, 32'd0);
        #1 check_output("t1_no_bypass", bus.mem_read_data, 32'h1111_1111);
        tick();
        apply_stimulus(30'd5, 1'b0, 32'd0, 1'b0, '0, 32'd0);
        #1 check_output("t1_forward", bus.mem_read_data, 32'hDEAD_BEEF);
        check_output("t1_count1", 32'(bus.wb_count), 32'd1);
        tick();
        check_output("t1_count0", 32'(bus.wb_count), 32'd0);
        check_output("t1_array",  bus.mem_read_data, 32'hDEAD_BEEF);

        // Backdoor held busy while the core stores to 1..6; the last two are dropped
        for (int k = 1; k <= 6; k++) begin
            apply_stimulus(30'(k), 1'b1, 32'(32'h100 + k), 1'b1,
                           DEPTH_LOG2'(200 + k), 32'(k));
            tick();
            check_output("t2_count", 32'(bus.wb_count), 32'((k < 4) ? k : 4));
            if (k == 4) begin
                check_output("t2_full",        32'(bus.wb_full),     32'd1);
                check_output("t2_no_overflow", 32'(bus.wb_overflow), 32'd0);
            end
            if (k == 5) begin
                check_output("t2_overflow", 32'(bus.wb_overflow), 32'd1);
            end
        end
        apply_stimulus(30'd6, 1'b0, 32'd0, 1'b0, '0, 32'd0);
        #1 check_output("t2_dropped", bus.mem_read_data, 32'h6666_6666);
        bus.mem_addr = 30'd4;
        #1 check_output("t2_fwd4", bus.mem_read_data, 32'h0000_0104);
        tick();
        check_output("t2_drain1", 32'(bus.wb_count), 32'd3);
        tick();
        tick();
        tick();
        check_output("t2_drained", 32'(bus.wb_count), 32'd0);
        check_output("t2_full_clr", 32'(bus.wb_full), 32'd0);
        bus.mem_addr = 30'd1;
        #1 check_output("t2_array1", bus.mem_read_data, 32'h0000_0101);
        bus.mem_addr = 30'd4;
        #1 check_output("t2_array4", bus.mem_read_data, 32'h0000_0104);
        bus.mem_addr = 30'd203;
        #1 check_output("t2_backdoor", bus.mem_read_data, 32'h0000_0003);
        check_output("t2_sticky", 32'(bus.wb_overflow), 32'd1);

        // Two stores to one address: the younger wins in forwarding and in the array
        apply_stimulus(30'd9, 1'b1, 32'h1, 1'b0, '0, 32'd0);
        tick();
        apply_stimulus(30'd9, 1'b1, 32'h2, 1'b0, '0, 32'd0);
        tick();
        apply_stimulus(30'd9, 1'b0, 32'd0, 1'b0, '0, 32'd0);
        #1 check_output("t3_forward", bus.mem_read_data, 32'h2);
        check_output("t3_count", 32'(bus.wb_count), 32'd1);
        tick();
        check_output("t3_array", bus.mem_read_data, 32'h2);

        // Out-of-range data access
        apply_stimulus(30'h2000_0000, 1'b1, 32'h0000_0BAD, 1'b0, '0, 32'd0);
        #1 check_output("t4_read_zero", bus.mem_read_data, 32'd0);
        check_output("t4_fault_pre", 32'(bus.addr_fault), 32'd0);
        tick();
        apply_stimulus(30'd0, 1'b0, 32'd0, 1'b0, '0, 32'd0);
        #1 check_output("t4_fault", 32'(bus.addr_fault), 32'd1);
        check_output("t4_no_push", 32'(bus.wb_count), 32'd0);
        check_output("t4_array0", bus.mem_read_data, 32'hCAFE_F00D);
        tick();
        check_output("t4_sticky", 32'(bus.addr_fault), 32'd1);

        // Reset with three stores still buffered
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(30'(20 + k), 1'b1, 32'(32'hE0 + k), 1'b1,
                           DEPTH_LOG2'(300 + k), 32'd0);
            tick();
        end
        apply_stimulus(30'd20, 1'b0, 32'd0, 1'b0, '0, 32'd0);
        #1 check_output("t5_count3", 32'(bus.wb_count), 32'd3);
        check_output("t5_fwd", bus.mem_read_data, 32'h0000_00E0);
        rst_n = 1'b0;
        #1 check_output("t5_count0", 32'(bus.wb_count), 32'd0);
        check_output("t5_overflow", 32'(bus.wb_overflow), 32'd0);
        check_output("t5_fault", 32'(bus.addr_fault), 32'd0);
        check_output("t5_array20", bus.mem_read_data, 32'h2020_2020);
        #2 rst_n = 1'b1;
        tick();
        check_output("t5_after", bus.mem_read_data, 32'h2020_2020);
        check_output("t5_count_after", 32'(bus.wb_count), 32'd0);

        // Fetch forwarding over a backdoor-loaded instruction
        apply_stimulus(30'd0, 1'b0, 32'd0, 1'b1, '0, 32'h0050_0093);
        bus.pc = 30'd0;
        tick();
        apply_stimulus(30'd0, 1'b0, 32'd0, 1'b0, '0, 32'd0);
        #1 check_output("t6_loaded", bus.instr, 32'h0050_0093);
        apply_stimulus(30'd0, 1'b1, 32'h13, 1'b0, '0, 32'd0);
        tick();
        apply_stimulus(30'd0, 1'b0, 32'd0, 1'b0, '0, 32'd0);
        #1 check_output("t6_fwd", bus.instr, 32'h13);
        check_output("t6_count", 32'(bus.wb_count), 32'd1);
        tick();
        check_output("t6_array", bus.instr, 32'h13);
        check_output("t6_count0", 32'(bus.wb_count), 32'd0);
        bus.pc = 30'd5;
        #1 check_output("t6_pc5", bus.instr, 32'hDEAD_BEEF);
        bus.pc = 30'h2000_0005;
        #1 check_output("t6_pc_nop", bus.instr, 32'h0000_0013);
        tick();
        check_output("t6_pc_nofault", 32'(bus.addr_fault), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
